pe_fg_select_stage: RTL and testbench

- Downstream consumer of the 8-bit combined adder/subtractor processing element in the polar SC decoder datapath.
- The PE produces sum = x+y, diff = x-y and the final borrow over unsigned LLR magnitudes. This stage turns those into a finished sign-magnitude LLR for either the f (min-sum) node or the g node.
- Two-stage pipeline with valid/ready backpressure at full throughput. It also emits a leaf hard decision that honours the frozen-bit flag.

---
 rtl/pe_fg_select_stage.sv | 145 ++++++++++++++
 tb/tb_pe_fg_select_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_fg_select_stage.sv
// Two-stage f/g select pipeline after the polar SC decoder add/sub PE.
// Stage A decodes the node operation from signs and PE borrow; stage B
// forms the final sign-magnitude LLR, leaf hard decision and saturation flag.
module pe_fg_select_stage #(
   parameter int W      = 8,
   parameter bit SAT_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         mode_g,
   input  logic         u_ps,
   input  logic         frozen,
   input  logic [W-1:0] x_mag,
   input  logic [W-1:0] y_mag,
   input  logic         x_sgn,
   input  logic         y_sgn,
   input  logic [W-1:0] pe_sum,
   input  logic [W-1:0] pe_diff,
   input  logic         pe_bout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_mag,
   output logic         out_sgn,
   output logic         u_hat,
   output logic         sat_flag
);

   typedef enum logic [1:0] {OP_F, OP_ADD, OP_NEG, OP_DIFF} op_e;

   logic         enA, enB;
   logic         vA_q, vB_q;
   op_e          opA_q, opA_d;
   logic         sgnA_q, sgnA_d;
   logic         carryA_q, carryA_d;
   logic         frzA_q;
   logic [W-1:0] fmagA_q, fmagA_d;
   logic [W-1:0] sumA_q, diffA_q;
   logic         ex;

   logic [W-1:0] magB_q, magB_d, mag_sel;
   logic         sgnB_q, sgnB_d;
   logic         uhB_q, uhB_d;
   logic         satB_q, satB_d, sat_sel;

   // A stage may advance when it is empty or when B is advancing too
   assign enB      = !vB_q | out_ready;
   assign enA      = !vA_q | enB;
   assign in_ready = enA;

   // Decode node operation and result sign from operand signs and PE borrow
   always_comb begin
      ex       = x_sgn ^ u_ps;
      opA_d    = OP_F;
      sgnA_d   = x_sgn ^ y_sgn;
      fmagA_d  = pe_bout ? x_mag : y_mag;
      // a wrapped sum is smaller than either addend
      carryA_d = (pe_sum < x_mag);
      if (mode_g) begin
         if (ex == y_sgn) begin
            opA_d  = OP_ADD;
            sgnA_d = y_sgn;
         end else if (pe_bout) begin
            opA_d  = OP_NEG;
            sgnA_d = y_sgn;
         end else begin
            opA_d  = OP_DIFF;
            sgnA_d = ex;
         end
      end
   end

   // Stage A register bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vA_q     <= 1'b0;
         opA_q    <= OP_F;
         sgnA_q   <= 1'b0;
         carryA_q <= 1'b0;
         frzA_q   <= 1'b0;
         fmagA_q  <= '0;
         sumA_q   <= '0;
         diffA_q  <= '0;
      end else if (enA) begin
         vA_q     <= in_valid;
         opA_q    <= opA_d;
         sgnA_q   <= sgnA_d;
         carryA_q <= carryA_d;
         frzA_q   <= frozen;
         fmagA_q  <= fmagA_d;
         sumA_q   <= pe_sum;
         diffA_q  <= pe_diff;
      end
   end

   // Final magnitude; bubbles load zeros so the outputs read 0 when not valid
   always_comb begin
      sat_sel = 1'b0;
      case (opA_q)
         OP_ADD: begin
            sat_sel = SAT_EN && carryA_q;
            mag_sel = sat_sel ? {W{1'b1}} : sumA_q;
         end
         OP_NEG:  mag_sel = '0 - diffA_q;
         OP_DIFF: mag_sel = diffA_q;
         default: mag_sel = fmagA_q;
      endcase
      magB_d = '0;
      satB_d = 1'b0;
      sgnB_d = 1'b0;
      uhB_d  = 1'b0;
      if (vA_q) begin
         magB_d = mag_sel;
         satB_d = sat_sel;
         // zero has no sign
         sgnB_d = sgnA_q & (mag_sel != '0);
         uhB_d  = sgnB_d & !frzA_q;
      end
   end

   // Stage B register bank drives the outputs directly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vB_q   <= 1'b0;
         magB_q <= '0;
         sgnB_q <= 1'b0;
         uhB_q  <= 1'b0;
         satB_q <= 1'b0;
      end else if (enB) begin
         vB_q   <= vA_q;
         magB_q <= magB_d;
         sgnB_q <= sgnB_d;
         uhB_q  <= uhB_d;
         satB_q <= satB_d;
      end
   end

   assign out_valid = vB_q;
   assign out_mag   = magB_q;
   assign out_sgn   = sgnB_q;
   assign u_hat     = uhB_q;
   assign sat_flag  = satB_q;

endmodule

// File: tb/tb_pe_fg_select_stage.sv
// Scoreboard bench for pe_fg_select_stage: one saturating and one wrapping
// instance share stimulus; expectations come from signed-LLR arithmetic.
module tb_pe_fg_select_stage;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         mode_g = 1'b0, u_ps = 1'b0, frozen = 1'b0;
   logic [W-1:0] x_mag = '0, y_mag = '0, pe_sum = '0, pe_diff = '0;
   logic         x_sgn = 1'b0, y_sgn = 1'b0, pe_bout = 1'b0;
   logic         out_ready = 1'b1;
   logic         in_ready1, out_valid1, out_sgn1, u_hat1, sat_flag1;
   logic         in_ready0, out_valid0, out_sgn0, u_hat0, sat_flag0;
   logic [W-1:0] out_mag1, out_mag0;

   always #5 clk = ~clk;

   pe_fg_select_stage #(.W(W), .SAT_EN(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .mode_g(mode_g), .u_ps(u_ps), .frozen(frozen), .x_mag(x_mag), .y_mag(y_mag),
      .x_sgn(x_sgn), .y_sgn(y_sgn), .pe_sum(pe_sum), .pe_diff(pe_diff),
      .pe_bout(pe_bout), .out_valid(out_valid1), .out_ready(out_ready),
      .out_mag(out_mag1), .out_sgn(out_sgn1), .u_hat(u_hat1), .sat_flag(sat_flag1));

   pe_fg_select_stage #(.W(W), .SAT_EN(1'b0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .mode_g(mode_g), .u_ps(u_ps), .frozen(frozen), .x_mag(x_mag), .y_mag(y_mag),
      .x_sgn(x_sgn), .y_sgn(y_sgn), .pe_sum(pe_sum), .pe_diff(pe_diff),
      .pe_bout(pe_bout), .out_valid(out_valid0), .out_ready(out_ready),
      .out_mag(out_mag0), .out_sgn(out_sgn0), .u_hat(u_hat0), .sat_flag(sat_flag0));

   typedef struct {
      int mag1; bit sgn1; bit sat1; bit uh1;
      int mag0; bit sgn0; bit sat0; bit uh0;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0, bad = 0, n_out = 0;
   bit   rnd_rdy = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Reference: f = sign(x)sign(y)min(|x|,|y|), g = (1-2u)Lx + Ly
   function automatic exp_t model(input int x, input bit xs, input int y, input bit ys,
                                  input bit m, input bit u, input bit fr);
      exp_t e;
      int lx, ly, r, a;
      lx = xs ? -x : x;
      ly = ys ? -y : y;
      if (!m) begin
         e.mag1 = (x < y) ? x : y;
         e.mag0 = e.mag1;
         e.sgn1 = xs ^ ys;
         e.sgn0 = e.sgn1;
         e.sat1 = 1'b0;
         e.sat0 = 1'b0;
      end else begin
         r = ly + (u ? -lx : lx);
         a = (r < 0) ? -r : r;
         e.sat1 = (a > 255);
         e.mag1 = e.sat1 ? 255 : a;
         e.mag0 = a % 256;
         e.sat0 = 1'b0;
         e.sgn1 = (r < 0);
         e.sgn0 = (r < 0);
      end
      if (e.mag1 == 0) e.sgn1 = 1'b0;
      if (e.mag0 == 0) e.sgn0 = 1'b0;
      e.uh1 = fr ? 1'b0 : e.sgn1;
      e.uh0 = fr ? 1'b0 : e.sgn0;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge following acceptance
   task automatic send(input int x, input bit xs, input int y, input bit ys,
                       input bit m, input bit u, input bit fr);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1;
      x_mag = W'(x); y_mag = W'(y); x_sgn = xs; y_sgn = ys;
      mode_g = m; u_ps = u; frozen = fr;
      pe_sum = W'(x + y); pe_diff = W'(x - y); pe_bout = (x < y);
      for (int t = 0; t < 200 && !acc; t++) begin
         #1;
         acc = in_ready1;
         @(posedge clk);
         if (acc) exp_q.push_back(model(x, xs, y, ys, m, u, fr));
         @(negedge clk);
      end
      if (!acc) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      send($urandom_range(0, 255), 1'($urandom), $urandom_range(0, 255), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // After a send into an empty pipe: nothing one cycle on, result the next
   task automatic latency_check(input string name);
      #1 chk({name, "_lat1"}, out_valid1, 0);
      @(negedge clk);
      #1 chk({name, "_lat2"}, out_valid1, 1);
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   // Random downstream readiness
   always @(negedge clk) if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);

   // Monitor: compare on every output transfer, bubbles must read zero
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst_n) begin
         chk("valid_pair", out_valid0, out_valid1);
         if (out_valid1 && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               n_out++;
               chk("mag_sat",  out_mag1,  e.mag1);
               chk("sgn_sat",  out_sgn1,  e.sgn1);
               chk("sat_sat",  sat_flag1, e.sat1);
               chk("uhat_sat", u_hat1,    e.uh1);
               chk("mag_wrap", out_mag0,  e.mag0);
               chk("sgn_wrap", out_sgn0,  e.sgn0);
               chk("sat_wrap", sat_flag0, e.sat0);
               chk("uhat_wrap", u_hat0,   e.uh0);
            end
         end else if (!out_valid1) begin
            chk("bubble_zero", {out_mag1, out_sgn1, u_hat1, sat_flag1}, 0);
         end
      end
   end

   initial begin
      bit saw_stall;
      int n0;
      #12;
      chk("rst_valid", out_valid1, 0);
      chk("rst_ready", in_ready1, 1);
      chk("rst_outs", {out_mag1, out_sgn1, u_hat1, sat_flag1}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // directed vectors, each into an empty pipe
      send(20, 0, 35, 1, 0, 0, 0);  latency_check("f_min");
      send(200, 0, 100, 0, 1, 0, 0); latency_check("g_add_sat");
      send(30, 0, 50, 1, 1, 0, 0);  latency_check("g_negdiff");
      send(30, 0, 50, 1, 1, 0, 1);  latency_check("g_frozen");
      send(90, 0, 40, 0, 1, 1, 0);  latency_check("g_diff_ups");
      send(7, 0, 7, 1, 1, 0, 0);    latency_check("g_equal");
      send(7, 1, 7, 0, 0, 0, 0);    latency_check("f_equal");
      send(128, 1, 128, 1, 1, 0, 0); latency_check("g_wrap_zero");
      send(200, 1, 100, 1, 1, 0, 0); latency_check("g_add_neg");
      drain("directed");

      // backpressure: 6 back-to-back items, downstream stalled for cycles 3-5
      saw_stall = 1'b0;
      n0 = n_out;
      fork
         for (int i = 0; i < 6; i++) send(10 * i + 5, 1'(i), 3 * i + 1, 1'(i >> 1), 1'(i), 0, 0);
         for (int c = 0; c < 14; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            #1 if (!in_ready1) saw_stall = 1'b1;
            @(negedge clk);
         end
      join
      out_ready = 1'b1;
      drain("bp");
      chk("bp_stall_seen", saw_stall, 1);
      chk("bp_count", n_out - n0, 6);

      // reset with two items in flight
      out_ready = 1'b0;
      send(11, 0, 22, 1, 0, 0, 0);
      send(33, 1, 44, 1, 1, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid1, 0);
      chk("midrst_ready", in_ready1, 1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      send(60, 0, 61, 0, 1, 1, 0);
      latency_check("post_rst");
      drain("post_rst");

      // random traffic with random gaps and random backpressure
      rnd_rdy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         send_rand();
      end
      rnd_rdy = 1'b0;
      out_ready = 1'b1;
      drain("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
